// File: rtl/aiu_sfi_snp_responder_pkg.sv
// Shared definitions for the AIU-side SFI snoop responder.
// Holds the MsgType encodings, the sfiPriv field positions, the line-state
// encoding, the snoop result layout, response status and error codes, and
// the helpers that classify a request and evaluate a snoop against a state.
package aiu_sfi_snp_responder_pkg;

    // MsgType encodings carried in sfiPriv[4:0]
    localparam logic [4:0] MSG_SNP_CLN_DTR = 5'h01;
    localparam logic [4:0] MSG_SNP_VLD_DTR = 5'h02;
    localparam logic [4:0] MSG_SNP_INV_DTR = 5'h03;
    localparam logic [4:0] MSG_SNP_INV     = 5'h04;
    localparam logic [4:0] MSG_STR_STATE   = 5'h10;

    // sfiPriv field positions (request side)
    localparam int unsigned PRIV_MSG_LSB     = 0;
    localparam int unsigned PRIV_MSG_MSB     = 4;
    localparam int unsigned PRIV_AIU_ID_LSB  = 5;
    localparam int unsigned PRIV_AIU_ID_MSB  = 7;
    localparam int unsigned PRIV_AIU_TID_LSB = 8;
    localparam int unsigned PRIV_AIU_TID_MSB = 13;
    localparam int unsigned PRIV_COHER_LSB   = 14;
    localparam int unsigned PRIV_COHER_MSB   = 17;

    // Response status / error codes
    localparam logic [1:0] RSP_STATUS_OK      = 2'd0;
    localparam logic [1:0] RSP_STATUS_ERR     = 2'd2;
    localparam logic [2:0] ERR_NONE           = 3'd0;
    localparam logic [2:0] ERR_UNSUPPORTED_MSG = 3'd1;

    typedef enum logic [1:0] {
        LS_I  = 2'd0,
        LS_SC = 2'd1,
        LS_UC = 2'd2,
        LS_UD = 2'd3
    } line_state_t;

    typedef struct packed {
        logic rv;
        logic rs;
        logic dc;
        logic dt;
    } snp_result_t;

    typedef enum logic [1:0] {
        MK_SNP,
        MK_STR,
        MK_ERR
    } msg_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EVAL,
        ST_RESP
    } rsp_state_t;

    typedef struct packed {
        snp_result_t result;
        line_state_t new_state;
        logic        upd;
    } snp_eval_t;

    function automatic msg_kind_t msg_kind(input logic [4:0] msg);
        msg_kind_t k;
        case (msg)
            MSG_SNP_CLN_DTR,
            MSG_SNP_VLD_DTR,
            MSG_SNP_INV_DTR,
            MSG_SNP_INV:     k = MK_SNP;
            MSG_STR_STATE:   k = MK_STR;
            default:         k = MK_ERR;
        endcase
        return k;
    endfunction

    // A line in I produces an empty result and no state write; otherwise
    // the snoop type decides whether we keep a shared copy or invalidate.
    function automatic snp_eval_t snp_eval(input logic [4:0] msg, input line_state_t st);
        snp_eval_t r;
        r = '0;
        if (st != LS_I) begin
            r.upd       = 1'b1;
            r.result.dc = (st == LS_UD);
            case (msg)
                MSG_SNP_CLN_DTR,
                MSG_SNP_VLD_DTR: begin
                    r.result.rv = 1'b1;
                    r.result.rs = 1'b1;
                    r.result.dt = 1'b1;
                    r.new_state = LS_SC;
                end
                MSG_SNP_INV_DTR: begin
                    r.result.dt = 1'b1;
                    r.new_state = LS_I;
                end
                default: begin
                    r.new_state = LS_I;
                end
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/aiu_sfi_snp_responder_req_fifo.sv
// aiu_sfi_req_fifo: synchronous FIFO buffering SFI requests as
// {transId, addr, sfiPriv}. Head entry is presented combinationally.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  push; also accepted when full if rd_en pops the same cycle
//   rd_en, rd_data  pop; rd_data is the current head
//   empty, full     occupancy flags
module aiu_sfi_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 58
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/aiu_sfi_snp_responder.sv
// aiu_sfi_snp_responder: AIU-side responder for the SFI coherence link.
// Accepts SNPreq / STRreq from the DCE master port, looks up and updates the
// local line state, and returns SNPrsp / STRrsp strictly in acceptance order.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_vld/req_rdy/req_*             SFI request channel
//   rsp_vld/rsp_rdy/rsp_*             SFI response channel
//   lk_vld/lk_addr, lk_state          state lookup (lk_state valid cycle after lk_vld)
//   upd_vld/upd_addr/upd_state        state write
//   str_vld/str_result                STRreq notification with its coherResult
module aiu_sfi_snp_responder
    import aiu_sfi_snp_responder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned TID_W      = 8,
    parameter int unsigned PRIV_W     = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [TID_W-1:0]  req_transId,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [PRIV_W-1:0] req_sfiPriv,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [TID_W-1:0]  rsp_transId,
    output logic [1:0]        rsp_status,
    output logic [2:0]        rsp_errCode,
    output logic [PRIV_W-1:0] rsp_sfiPriv,
    output logic              lk_vld,
    output logic [ADDR_W-1:0] lk_addr,
    input  logic [1:0]        lk_state,
    output logic              upd_vld,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [1:0]        upd_state,
    output logic              str_vld,
    output logic [3:0]        str_result
);

    localparam int unsigned ENTRY_W = TID_W + ADDR_W + PRIV_W;

    rsp_state_t        state;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ENTRY_W-1:0] head;
    logic [TID_W-1:0]  head_tid;
    logic [ADDR_W-1:0] head_addr;
    logic [PRIV_W-1:0] head_priv;
    logic [4:0]        head_msg;
    msg_kind_t         head_kind;

    logic [TID_W-1:0]  cur_tid;
    logic [ADDR_W-1:0] cur_addr;
    logic [4:0]        cur_msg;
    snp_eval_t         eval_r;

    logic              unused_priv_bits;

    aiu_sfi_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_push),
        .wr_data ({req_transId, req_addr, req_sfiPriv}),
        .rd_en   (fifo_pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign {head_tid, head_addr, head_priv} = head;
    assign head_msg  = head_priv[PRIV_MSG_MSB:PRIV_MSG_LSB];
    assign head_kind = msg_kind(head_msg);

    // Requester AIU id / transId are not needed to form the response.
    assign unused_priv_bits = ^head_priv[PRIV_AIU_TID_MSB:PRIV_AIU_ID_LSB];

    assign req_rdy   = !rst && !fifo_full;
    assign fifo_push = req_vld && req_rdy;

    // Pop from IDLE, or straight out of RESP on the response handshake so
    // queued requests issue back-to-back without an IDLE bubble.
    assign fifo_pop = !rst && !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_RESP) && rsp_rdy));

    assign eval_r = snp_eval(cur_msg, line_state_t'(lk_state));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_tid     <= '0;
            cur_addr    <= '0;
            cur_msg     <= '0;
            rsp_vld     <= 1'b0;
            rsp_transId <= '0;
            rsp_status  <= '0;
            rsp_errCode <= '0;
            rsp_sfiPriv <= '0;
            lk_vld      <= 1'b0;
            lk_addr     <= '0;
            upd_vld     <= 1'b0;
            upd_addr    <= '0;
            upd_state   <= '0;
            str_vld     <= 1'b0;
            str_result  <= '0;
        end else begin
            lk_vld  <= 1'b0;
            upd_vld <= 1'b0;
            str_vld <= 1'b0;
            if (fifo_pop) begin
                cur_tid  <= head_tid;
                cur_addr <= head_addr;
                cur_msg  <= head_msg;
                case (head_kind)
                    MK_SNP: begin
                        state   <= ST_LOOKUP;
                        lk_vld  <= 1'b1;
                        lk_addr <= head_addr;
                        rsp_vld <= 1'b0;
                    end
                    MK_STR: begin
                        state       <= ST_RESP;
                        rsp_vld     <= 1'b1;
                        rsp_transId <= head_tid;
                        rsp_status  <= RSP_STATUS_OK;
                        rsp_errCode <= ERR_NONE;
                        rsp_sfiPriv <= '0;
                        str_vld     <= 1'b1;
                        str_result  <= head_priv[PRIV_COHER_MSB:PRIV_COHER_LSB];
                    end
                    default: begin
                        state       <= ST_RESP;
                        rsp_vld     <= 1'b1;
                        rsp_transId <= head_tid;
                        rsp_status  <= RSP_STATUS_ERR;
                        rsp_errCode <= ERR_UNSUPPORTED_MSG;
                        rsp_sfiPriv <= '0;
                    end
                endcase
            end else begin
                case (state)
                    ST_LOOKUP: begin
                        state <= ST_EVAL;
                    end
                    ST_EVAL: begin
                        state       <= ST_RESP;
                        rsp_vld     <= 1'b1;
                        rsp_transId <= cur_tid;
                        rsp_status  <= RSP_STATUS_OK;
                        rsp_errCode <= ERR_NONE;
                        rsp_sfiPriv <= {{(PRIV_W-4){1'b0}}, eval_r.result};
                        if (eval_r.upd) begin
                            upd_vld   <= 1'b1;
                            upd_addr  <= cur_addr;
                            upd_state <= eval_r.new_state;
                        end
                    end
                    ST_RESP: begin
                        if (rsp_rdy) begin
                            rsp_vld <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aiu_sfi_snp_responder.sv
// Self-checking bench for aiu_sfi_snp_responder: directed cases followed by
// randomized traffic, checked by a scoreboard fed from a reference model.
module tb_aiu_sfi_snp_responder;
    import aiu_sfi_snp_responder_pkg::*;

    localparam int FD = 4;
    localparam int AW = 32;
    localparam int TW = 8;
    localparam int PW = 18;

    logic          clk;
    logic          rst;
    logic          req_vld;
    logic          req_rdy;
    logic [TW-1:0] req_transId;
    logic [AW-1:0] req_addr;
    logic [PW-1:0] req_sfiPriv;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [TW-1:0] rsp_transId;
    logic [1:0]    rsp_status;
    logic [2:0]    rsp_errCode;
    logic [PW-1:0] rsp_sfiPriv;
    logic          lk_vld;
    logic [AW-1:0] lk_addr;
    logic [1:0]    lk_state;
    logic          upd_vld;
    logic [AW-1:0] upd_addr;
    logic [1:0]    upd_state;
    logic          str_vld;
    logic [3:0]    str_result;

    aiu_sfi_snp_responder #(
        .FIFO_DEPTH (FD),
        .ADDR_W     (AW),
        .TID_W      (TW),
        .PRIV_W     (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_transId (req_transId),
        .req_addr    (req_addr),
        .req_sfiPriv (req_sfiPriv),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_transId (rsp_transId),
        .rsp_status  (rsp_status),
        .rsp_errCode (rsp_errCode),
        .rsp_sfiPriv (rsp_sfiPriv),
        .lk_vld      (lk_vld),
        .lk_addr     (lk_addr),
        .lk_state    (lk_state),
        .upd_vld     (upd_vld),
        .upd_addr    (upd_addr),
        .upd_state   (upd_state),
        .str_vld     (str_vld),
        .str_result  (str_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tid;
        logic [1:0]    status;
        logic [2:0]    err;
        logic [PW-1:0] priv;
    } exp_rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    st;
    } exp_upd_t;

    exp_rsp_t      rsp_q[$];
    logic [AW-1:0] lk_q[$];
    exp_upd_t      upd_q[$];
    logic [3:0]    str_q[$];

    int vectors    = 0;
    int miscompares = 0;

    logic [AW-1:0] addr_tab [4];
    logic [1:0]    env_mem  [4];   // line states as seen by the lookup port
    logic [1:0]    model_mem[4];   // reference model's view, advanced at acceptance

    logic          lk_hold;
    logic          prev_stall;
    logic [30:0]   prev_fields;
    int            rsp_seen;
    logic          rnd_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired got timeout expected event", name);
    endtask

    function automatic int addr_idx(input logic [AW-1:0] a);
        for (int i = 0; i < 4; i++) if (addr_tab[i] == a) return i;
        return 0;
    endfunction

    // Reference model: requests are served one at a time in acceptance order,
    // so the line state each snoop sees is the model state at acceptance.
    function automatic void model_push(input logic [TW-1:0] tid, input logic [AW-1:0] addr,
                                       input logic [PW-1:0] priv);
        exp_rsp_t e;
        exp_upd_t u;
        logic [4:0] msg;
        logic [1:0] st;
        logic keep;
        int i;
        msg = priv[4:0];
        e.tid = tid;
        e.status = 2'd0;
        e.err = 3'd0;
        e.priv = '0;
        if (msg == MSG_STR_STATE) begin
            str_q.push_back(priv[17:14]);
        end else if (msg == MSG_SNP_CLN_DTR || msg == MSG_SNP_VLD_DTR ||
                     msg == MSG_SNP_INV_DTR || msg == MSG_SNP_INV) begin
            lk_q.push_back(addr);
            i = addr_idx(addr);
            st = model_mem[i];
            if (st != 2'd0) begin
                keep = (msg == MSG_SNP_CLN_DTR || msg == MSG_SNP_VLD_DTR);
                e.priv[3] = keep;
                e.priv[2] = keep;
                e.priv[1] = (st == 2'd3);
                e.priv[0] = (msg != MSG_SNP_INV);
                u.addr = addr;
                u.st = keep ? 2'd1 : 2'd0;
                upd_q.push_back(u);
                model_mem[i] = u.st;
            end
        end else begin
            e.status = 2'd2;
            e.err = 3'd1;
        end
        rsp_q.push_back(e);
    endfunction

    // Drive one request (called at posedge+1) and hold it until accepted.
    task automatic send(input logic [TW-1:0] tid, input logic [AW-1:0] addr, input logic [PW-1:0] priv);
        int n;
        req_vld = 1'b1;
        req_transId = tid;
        req_addr = addr;
        req_sfiPriv = priv;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_rdy) break;
            n++;
            if (n > 300) begin
                bound_fail("req_accept");
                break;
            end
        end
        if (req_rdy) model_push(tid, addr, priv);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rsp_q.size() != 0 || lk_q.size() != 0 || upd_q.size() != 0 ||
               str_q.size() != 0 || rsp_vld) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                bound_fail("drain");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic latency(input string name, input int exp);
        int n;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (rsp_vld) break;
        end
        chk(name, 64'(n), 64'(exp));
    endtask

    function automatic logic [PW-1:0] mk_priv(input logic [4:0] msg, input logic [3:0] coher);
        logic [PW-1:0] p;
        p = PW'($urandom);
        p[4:0] = msg;
        p[17:14] = coher;
        return p;
    endfunction

    // Monitor and lookup-port environment, sampled mid-cycle.
    always @(negedge clk) begin
        exp_rsp_t e;
        exp_upd_t u;
        logic [3:0] s;
        logic [AW-1:0] a;
        if (rst) begin
            prev_stall = 1'b0;
            lk_hold = 1'b0;
        end else begin
            if (lk_vld) begin
                lk_state = env_mem[addr_idx(lk_addr)];
                lk_hold = 1'b1;
            end else if (lk_hold) begin
                lk_hold = 1'b0;
            end else begin
                lk_state = 2'($urandom_range(0, 3));
            end
            if (upd_vld) env_mem[addr_idx(upd_addr)] = upd_state;

            if (prev_stall && rsp_vld)
                chk("rsp_stable", 64'({rsp_transId, rsp_status, rsp_errCode, rsp_sfiPriv}),
                    64'(prev_fields));
            if (rsp_vld && rsp_rdy) begin
                rsp_seen++;
                if (rsp_q.size() == 0) begin
                    bound_fail("rsp_unexpected");
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_transId", 64'(rsp_transId), 64'(e.tid));
                    chk("rsp_status", 64'(rsp_status), 64'(e.status));
                    chk("rsp_errCode", 64'(rsp_errCode), 64'(e.err));
                    chk("rsp_sfiPriv", 64'(rsp_sfiPriv), 64'(e.priv));
                end
            end
            if (lk_vld) begin
                if (lk_q.size() == 0) bound_fail("lk_unexpected");
                else begin
                    a = lk_q.pop_front();
                    chk("lk_addr", 64'(lk_addr), 64'(a));
                end
            end
            if (upd_vld) begin
                if (upd_q.size() == 0) bound_fail("upd_unexpected");
                else begin
                    u = upd_q.pop_front();
                    chk("upd_addr", 64'(upd_addr), 64'(u.addr));
                    chk("upd_state", 64'(upd_state), 64'(u.st));
                end
            end
            if (str_vld) begin
                if (str_q.size() == 0) bound_fail("str_unexpected");
                else begin
                    s = str_q.pop_front();
                    chk("str_result", 64'(str_result), 64'(s));
                end
            end
            prev_stall = rsp_vld && !rsp_rdy;
            prev_fields = {rsp_transId, rsp_status, rsp_errCode, rsp_sfiPriv};
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        addr_tab[0] = 32'h0000_1000;
        addr_tab[1] = 32'h0000_2040;
        addr_tab[2] = 32'h0000_3080;
        addr_tab[3] = 32'h0000_40C0;
        for (int i = 0; i < 4; i++) begin
            env_mem[i] = 2'd3;
            model_mem[i] = 2'd3;
        end
        rst = 1'b1;
        req_vld = 1'b0;
        req_transId = '0;
        req_addr = '0;
        req_sfiPriv = '0;
        rsp_rdy = 1'b0;
        lk_state = '0;
        lk_hold = 1'b0;
        prev_stall = 1'b0;
        prev_fields = '0;
        rsp_seen = 0;
        rnd_done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 64'(req_rdy), 64'(0));
        chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
        chk("rst_lk_vld", 64'(lk_vld), 64'(0));
        chk("rst_upd_vld", 64'(upd_vld), 64'(0));
        chk("rst_str_vld", 64'(str_vld), 64'(0));
        chk("rst_rsp_fields", 64'({rsp_transId, rsp_status, rsp_errCode, rsp_sfiPriv}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("req_rdy_after_rst", 64'(req_rdy), 64'(1));
        @(posedge clk);
        #1;

        // SNP_CLN_DTR on a UD line
        env_mem[0] = 2'd3;
        model_mem[0] = 2'd3;
        send(8'h21, addr_tab[0], mk_priv(MSG_SNP_CLN_DTR, 4'h0));
        req_vld = 1'b0;
        latency("lat_snp_cln", 4);
        drain();

        // SNP_INV on an I line: empty result, no update
        env_mem[1] = 2'd0;
        model_mem[1] = 2'd0;
        send(8'h22, addr_tab[1], mk_priv(MSG_SNP_INV, 4'h0));
        req_vld = 1'b0;
        latency("lat_snp_inv", 4);
        drain();

        // STR_STATE with coherResult 1010
        send(8'h23, addr_tab[2], mk_priv(MSG_STR_STATE, 4'b1010));
        req_vld = 1'b0;
        latency("lat_str", 2);
        drain();

        // Unsupported MsgType
        send(8'h24, addr_tab[3], mk_priv(5'h1F, 4'h0));
        req_vld = 1'b0;
        latency("lat_err", 2);
        drain();

        // Five back-to-back snoops with the response side stalled
        rsp_rdy = 1'b0;
        for (int k = 0; k < 5; k++)
            send(8'h40 + 8'(k), addr_tab[k % 4], mk_priv(MSG_SNP_VLD_DTR, 4'h0));
        req_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("req_rdy_full", 64'(req_rdy), 64'(0));
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
        drain();
        chk("b2b_rsp_count", 64'(rsp_seen), 64'(9));

        // Reset while a snoop is in EVAL with three requests queued
        for (int i = 0; i < 4; i++) begin
            env_mem[i] = 2'd2;
            model_mem[i] = 2'd2;
        end
        rsp_rdy = 1'b0;
        for (int k = 0; k < 5; k++)
            send(8'h60 + 8'(k), addr_tab[k % 4], mk_priv(MSG_SNP_INV_DTR, 4'h0));
        req_vld = 1'b0;
        n = 0;
        while (!rsp_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_vld) bound_fail("stall_rsp");
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
        @(negedge clk);
        chk("lk_before_rst", 64'(lk_vld), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        rsp_q.delete();
        lk_q.delete();
        upd_q.delete();
        str_q.delete();
        @(negedge clk);
        chk("rst_mid_rsp_vld", 64'(rsp_vld), 64'(0));
        chk("rst_mid_upd_vld", 64'(upd_vld), 64'(0));
        chk("rst_mid_req_rdy", 64'(req_rdy), 64'(0));
        for (int i = 0; i < 4; i++) model_mem[i] = env_mem[i];
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_rdy_after", 64'(req_rdy), 64'(1));
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_vld || lk_vld) cnt++;
        end
        chk("fifo_empty_after_rst", 64'(cnt), 64'(0));
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 4; i++) begin
            env_mem[i] = 2'($urandom_range(0, 3));
            model_mem[i] = env_mem[i];
        end
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    int r;
                    int gap;
                    logic [4:0] msg;
                    r = $urandom_range(0, 9);
                    case (r)
                        0, 1: msg = MSG_SNP_CLN_DTR;
                        2:    msg = MSG_SNP_VLD_DTR;
                        3:    msg = MSG_SNP_INV_DTR;
                        4:    msg = MSG_SNP_INV;
                        5, 6: msg = MSG_STR_STATE;
                        7:    msg = 5'($urandom_range(5, 15));
                        default: msg = MSG_SNP_INV_DTR;
                    endcase
                    send(8'($urandom), addr_tab[$urandom_range(0, 3)],
                         mk_priv(msg, 4'($urandom)));
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        req_vld = 1'b0;
                        repeat (gap) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                req_vld = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    rsp_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_rdy = 1'b1;
        drain();
        chk("end_rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        chk("end_upd_q_empty", 64'(upd_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
